// File: rtl/mmio_timer_responder_if.sv
// Load/store bus between the core data-memory port and the timer responder.
// Signal names follow the original core port names so the top-level wiring is unchanged.
interface mmio_timer_responder_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        hit;
   logic        irq;

   modport master (
      output MemRead, MemWrite, address, write_data,
      input  read_data, hit, irq
   );

   modport slave (
      input  MemRead, MemWrite, address, write_data,
      output read_data, hit, irq
   );
endinterface

// File: rtl/mmio_timer_responder.sv
// Memory-mapped timer: prescaled counter, compare register, sticky match flag and level irq.
// Reads are combinational in the access cycle; writes and counting update on the rising clk edge.
module mmio_timer_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   mmio_timer_responder_if.slave bus
);

   localparam logic [1:0] OFF_CTRL    = 2'd0;
   localparam logic [1:0] OFF_COUNT   = 2'd1;
   localparam logic [1:0] OFF_COMPARE = 2'd2;
   localparam logic [1:0] OFF_STATUS  = 2'd3;

   logic                  r_en;
   logic                  r_auto;
   logic                  r_irq_en;
   logic [PRESCALE_W-1:0] r_prescale;
   logic [PRESCALE_W-1:0] r_pre_cnt;
   logic [WIDTH-1:0]      r_count;
   logic [WIDTH-1:0]      r_compare;
   logic                  r_match;

   logic                  w_hit;
   logic [1:0]            w_off;
   logic                  w_wr;
   logic                  w_wr_ctrl;
   logic                  w_wr_count;
   logic                  w_wr_compare;
   logic                  w_wr_status;
   logic                  w_new_en;
   logic [PRESCALE_W-1:0] w_new_prescale;
   logic                  w_ctrl_restart;
   logic                  w_tick;
   logic                  w_cmp_eq;
   logic [WIDTH-1:0]      w_tick_count;
   logic [31:0]           w_ctrl_rd;
   logic [31:0]           w_count_rd;
   logic [31:0]           w_compare_rd;
   logic [31:0]           w_status_rd;
   logic                  w_unused;

   assign w_hit = (bus.address[31:4] == BASE_ADDR[31:4]);
   assign w_off = bus.address[3:2];
   assign w_wr  = bus.MemWrite && w_hit;

   assign w_wr_ctrl    = w_wr && (w_off == OFF_CTRL);
   assign w_wr_count   = w_wr && (w_off == OFF_COUNT);
   assign w_wr_compare = w_wr && (w_off == OFF_COMPARE);
   assign w_wr_status  = w_wr && (w_off == OFF_STATUS);

   assign w_new_en       = bus.write_data[0];
   assign w_new_prescale = bus.write_data[8 +: PRESCALE_W];
   // Restarting the prescaler only when EN or PRESCALE actually change keeps phase across benign CTRL writes.
   assign w_ctrl_restart = w_wr_ctrl &&
                           ((w_new_en != r_en) || (w_new_prescale != r_prescale));

   assign w_tick       = r_en && (r_pre_cnt == r_prescale);
   assign w_cmp_eq     = w_tick && (r_count == r_compare);
   assign w_tick_count = (w_cmp_eq && r_auto) ? '0 : r_count + WIDTH'(1);

   assign w_unused = ^{bus.address[1:0], bus.write_data};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_en       <= 1'b0;
         r_auto     <= 1'b0;
         r_irq_en   <= 1'b0;
         r_prescale <= '0;
      end else if (w_wr_ctrl) begin
         r_en       <= w_new_en;
         r_auto     <= bus.write_data[1];
         r_irq_en   <= bus.write_data[2];
         r_prescale <= w_new_prescale;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pre_cnt <= '0;
      end else if (w_ctrl_restart || !r_en || w_tick) begin
         r_pre_cnt <= '0;
      end else begin
         r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
      end
   end

   // A CPU write to COUNT wins over the tick update; the tick's compare already used the old COUNT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (w_wr_count) begin
         r_count <= bus.write_data[WIDTH-1:0];
      end else if (w_tick) begin
         r_count <= w_tick_count;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_compare <= '1;
      end else if (w_wr_compare) begin
         r_compare <= bus.write_data[WIDTH-1:0];
      end
   end

   // A match on the same edge as a write-1-clear keeps MATCH set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_match <= 1'b0;
      end else if (w_cmp_eq) begin
         r_match <= 1'b1;
      end else if (w_wr_status && bus.write_data[0]) begin
         r_match <= 1'b0;
      end
   end

   always_comb begin
      w_ctrl_rd                   = '0;
      w_ctrl_rd[0]                = r_en;
      w_ctrl_rd[1]                = r_auto;
      w_ctrl_rd[2]                = r_irq_en;
      w_ctrl_rd[8 +: PRESCALE_W]  = r_prescale;
      w_count_rd                  = '0;
      w_count_rd[WIDTH-1:0]       = r_count;
      w_compare_rd                = '0;
      w_compare_rd[WIDTH-1:0]     = r_compare;
      w_status_rd                 = '0;
      w_status_rd[0]              = r_match;
   end

   always_comb begin
      bus.read_data = '0;
      if (bus.MemRead && w_hit) begin
         unique case (w_off)
            OFF_CTRL:    bus.read_data = w_ctrl_rd;
            OFF_COUNT:   bus.read_data = w_count_rd;
            OFF_COMPARE: bus.read_data = w_compare_rd;
            OFF_STATUS:  bus.read_data = w_status_rd;
            default:     bus.read_data = '0;
         endcase
      end
   end

   assign bus.hit = w_hit;
   assign bus.irq = r_match && r_irq_en;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Scoreboard bench for mmio_timer_responder: directed scenarios plus random bus traffic,
// expected responses come from a register-level reference model of the timer.
module tb_mmio_timer_responder;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [31:0] A_CTRL = BASE + 32'h0;
   localparam logic [31:0] A_CNT  = BASE + 32'h4;
   localparam logic [31:0] A_CMP  = BASE + 32'h8;
   localparam logic [31:0] A_STAT = BASE + 32'hC;

   logic clk = 1'b0;
   logic rst;

   mmio_timer_responder_if bus();

   mmio_timer_responder #(
      .BASE_ADDR  (BASE),
      .WIDTH      (32),
      .PRESCALE_W (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        hit;
      logic        irq;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   bit          m_en, m_auto, m_irq_en, m_match, in_reset;
   int unsigned m_ps, m_pre, m_count, m_compare;

   function automatic void model_reset();
      m_en = 0; m_auto = 0; m_irq_en = 0; m_match = 0;
      m_ps = 0; m_pre = 0; m_count = 0; m_compare = 32'hFFFF_FFFF;
   endfunction

   function automatic bit m_hit(input logic [31:0] addr);
      return (addr >> 4) == (BASE >> 4);
   endfunction

   function automatic logic [31:0] m_read(input bit rd, input logic [31:0] addr);
      int unsigned idx;
      if (!rd || !m_hit(addr)) return 32'h0;
      idx = (addr >> 2) & 3;
      case (idx)
         0: return 32'(m_en) | (32'(m_auto) << 1) | (32'(m_irq_en) << 2) | (m_ps << 8);
         1: return m_count;
         2: return m_compare;
         default: return 32'(m_match);
      endcase
   endfunction

   // One clock edge of the timer described at register level.
   function automatic void m_step(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
      bit          tick, eq, hitw;
      int unsigned idx, n_pre, n_count, n_ps;
      bit          n_match;
      hitw    = wr && m_hit(addr);
      idx     = (addr >> 2) & 3;
      tick    = m_en && (m_pre == m_ps);
      eq      = tick && (m_count == m_compare);
      n_pre   = (m_en && !tick) ? m_pre + 1 : 0;
      n_count = m_count;
      if (tick) n_count = (eq && m_auto) ? 0 : m_count + 1;
      n_match = m_match;
      if (hitw && idx == 3 && wd[0]) n_match = 0;
      if (eq) n_match = 1;
      if (hitw) begin
         case (idx)
            0: begin
               n_ps = (wd >> 8) & 255;
               if (n_ps != m_ps || wd[0] != m_en) n_pre = 0;
               m_en = wd[0]; m_auto = wd[1]; m_irq_en = wd[2]; m_ps = n_ps;
            end
            1: n_count = wd;
            2: m_compare = wd;
            default: ;
         endcase
      end
      m_pre = n_pre; m_count = n_count; m_match = n_match;
   endfunction

   task automatic push_exp(input string name, input bit rd, input logic [31:0] addr);
      exp_t e;
      e.name  = name;
      e.rdata = m_read(rd, addr);
      e.hit   = m_hit(addr);
      e.irq   = m_match && m_irq_en;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1; holds inputs for one cycle, then advances the model at the edge.
   task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input string name, input bit chk);
      bus.MemRead = rd; bus.MemWrite = wr; bus.address = addr; bus.write_data = wd;
      if (rd || chk) push_exp(name, rd, addr);
      @(posedge clk);
      if (!in_reset) m_step(wr, addr, wd);
      #1;
   endtask

   task automatic rd(input logic [31:0] addr, input string name);
      access(1, 0, addr, 32'h0, name, 0);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
      access(0, 1, addr, wd, "", 0);
   endtask

   // Monitor: compare every presented response against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         if ({bus.hit, bus.irq, bus.read_data} !== {e.hit, e.irq, e.rdata}) begin
            bad++;
            $display("FAIL %s: got hit=%0b irq=%0b data=%h, want hit=%0b irq=%0b data=%h",
                     e.name, bus.hit, bus.irq, bus.read_data, e.hit, e.irq, e.rdata);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] addr, data;
      int unsigned op, off;

      rst = 1'b0; in_reset = 1; model_reset();
      bus.MemRead = 0; bus.MemWrite = 0; bus.address = 0; bus.write_data = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1; in_reset = 0;

      // Reset readback and decode boundaries
      rd(A_CTRL, "reset_ctrl");
      rd(A_CNT,  "reset_count");
      rd(A_CMP,  "reset_compare");
      rd(A_STAT, "reset_status");
      access(0, 0, A_CMP, 32'h0, "no_memread", 1);
      rd(32'h0000_2000, "outside_window");
      rd(BASE + 32'h10, "window_end");
      rd(BASE + 32'h7, "byte_offset_ignored");

      // Prescale timing: tick every 3 cycles, match at COUNT=3, no reload
      wr(A_CMP, 32'd3);
      wr(A_CTRL, 32'h0000_0205);
      for (int i = 0; i < 16; i++) rd(A_CNT, "prescale_count");
      rd(A_STAT, "prescale_match");

      // Auto-reload with IRQ disabled
      wr(A_CTRL, 32'h0);
      wr(A_CNT, 32'h0);
      wr(A_STAT, 32'h1);
      wr(A_CMP, 32'd5);
      wr(A_CTRL, 32'h0000_0003);
      for (int i = 0; i < 14; i++) rd(A_CNT, "autoreload_count");
      rd(A_STAT, "autoreload_match");

      // W1C on the same edge as a new match: set wins
      for (int i = 0; i < 20 && m_count != 5; i++) rd(A_CNT, "w1c_wait");
      access(1, 1, A_STAT, 32'h1, "w1c_race_prewrite", 0);
      rd(A_STAT, "w1c_race_set_wins");
      wr(A_CTRL, 32'h0000_0004);
      rd(A_STAT, "irq_enabled_match");
      wr(A_STAT, 32'h1);
      rd(A_STAT, "w1c_idle_clear");
      wr(A_STAT, 32'h0);
      rd(A_STAT, "w0_no_effect");

      // CPU COUNT write beats the tick; then silent wrap
      wr(A_CNT, 32'd10);
      wr(A_CMP, 32'd1000);
      wr(A_CTRL, 32'h0000_0001);
      rd(A_CNT, "count_before_override");
      wr(A_CNT, 32'd100);
      rd(A_CNT, "write_beats_tick");
      wr(A_CTRL, 32'h0);
      wr(A_CNT, 32'hFFFF_FFFF);
      wr(A_CMP, 32'd7);
      wr(A_STAT, 32'h1);
      wr(A_CTRL, 32'h0000_0001);
      rd(A_CNT, "wrap_pre");
      rd(A_CNT, "wrap_zero");
      rd(A_STAT, "wrap_no_match");

      // Asynchronous reset between clock edges while counting with irq live
      wr(A_CMP, 32'd2);
      wr(A_CTRL, 32'h0000_0005);
      repeat (6) rd(A_STAT, "pre_reset_irq");
      bus.MemRead = 1; bus.MemWrite = 0; bus.address = A_CNT;
      #2;
      rst = 1'b0; in_reset = 1; model_reset();
      push_exp("async_reset_count", 1, A_CNT);
      @(posedge clk);
      #1;
      rd(A_CTRL, "in_reset_ctrl");
      rd(A_STAT, "in_reset_status");
      rst = 1'b1; in_reset = 0;
      repeat (4) access(0, 0, 32'h0, 32'h0, "", 0);
      rd(A_CNT, "no_resume_after_reset");
      rd(A_CTRL, "ctrl_after_reset");

      // Random traffic against the model
      for (int i = 0; i < 800; i++) begin
         op   = $urandom_range(0, 9);
         off  = $urandom_range(0, 3);
         addr = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
         case (off)
            0: data = ($urandom & 32'hFFFF_F0F8) & ~32'h0000_FF00 |
                      32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 7));
            1: data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                                  : 32'($urandom_range(0, 12));
            2: data = 32'($urandom_range(0, 12));
            default: data = $urandom;
         endcase
         if (op <= 4)      rd(addr, "rand_read");
         else if (op <= 7) wr(addr, data);
         else if (op == 8) access(1, 1, addr, data, "rand_read_write", 0);
         else              access($urandom_range(0, 1), 1, $urandom, data, "rand_offwindow", 1);
      end

      access(0, 0, 32'h0, 32'h0, "", 0);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
